// File: rtl/dpram_uart_reader_if.sv
// Command, RAM read port and byte-transmitter handshake of the burst reader.
// slave = the reader itself; master = command logic, RAM and transmitter side.
interface dpram_uart_reader_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
);
  logic              Start;
  logic [ADDR_W-1:0] Start_addr;
  logic [LEN_W-1:0]  Length;
  logic              Abort;
  logic [ADDR_W-1:0] rdaddress;
  logic [7:0]        q;
  logic              Uart_send_en;
  logic [7:0]        Data_byte;
  logic              Uart_tx_done;
  logic              Busy;
  logic              Done;
  logic              Aborted;

  modport slave (
    input  Start, Start_addr, Length, Abort, q, Uart_tx_done,
    output rdaddress, Uart_send_en, Data_byte, Busy, Done, Aborted
  );
  modport master (
    output Start, Start_addr, Length, Abort, q, Uart_tx_done,
    input  rdaddress, Uart_send_en, Data_byte, Busy, Done, Aborted
  );
endinterface

// File: rtl/dpram_uart_reader.sv
// Reads a contiguous RAM burst and feeds it byte-by-byte to the UART transmitter,
// optionally followed by an 8-bit additive checksum byte.
module dpram_uart_reader #(
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 9,
  parameter int RD_LAT     = 2,
  parameter int APPEND_SUM = 1
) (
  input logic              Clk,
  input logic              Rst_n,
  dpram_uart_reader_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, RD_WAIT, SEND, WAIT_DONE, SUM_SEND, SUM_WAIT, FINISH
  } state_e;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rdaddress_q, rdaddress_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [7:0]        data_byte_q, data_byte_d;
  logic [7:0]        sum_q, sum_d;
  logic [1:0]        lat_q, lat_d;
  logic              send_en_q, send_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  always_comb begin
    state_d     = state_q;
    rdaddress_d = rdaddress_q;
    remaining_d = remaining_q;
    data_byte_d = data_byte_q;
    sum_d       = sum_q;
    lat_d       = lat_q;
    aborted_d   = aborted_q;
    send_en_d   = 1'b0;
    done_d      = 1'b0;
    // Busy drops the clock after the Done pulse, so it covers the Done cycle.
    busy_d      = busy_q & ~done_q;
    case (state_q)
      IDLE: if (bus.Start) begin
        rdaddress_d = bus.Start_addr;
        remaining_d = bus.Length;
        sum_d       = '0;
        busy_d      = 1'b1;
        aborted_d   = 1'b0;
        lat_d       = LAT;
        state_d     = (bus.Length == '0) ? FINISH : RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q <= 2'd1) state_d = SEND;
        else               lat_d   = lat_q - 2'd1;
      end
      SEND: begin
        data_byte_d = bus.q;
        send_en_d   = 1'b1;
        sum_d       = sum_q + bus.q;
        remaining_d = remaining_q - LEN_W'(1);
        state_d     = WAIT_DONE;
      end
      WAIT_DONE: if (bus.Uart_tx_done) begin
        if (bus.Abort) begin
          aborted_d = 1'b1;
          state_d   = FINISH;
        end else if (remaining_q != '0) begin
          rdaddress_d = rdaddress_q + ADDR_W'(1);
          lat_d       = LAT;
          state_d     = RD_WAIT;
        end else if (APPEND_SUM != 0) begin
          state_d = SUM_SEND;
        end else begin
          state_d = FINISH;
        end
      end
      SUM_SEND: begin
        data_byte_d = sum_q;
        send_en_d   = 1'b1;
        state_d     = SUM_WAIT;
      end
      SUM_WAIT: if (bus.Uart_tx_done) state_d = FINISH;
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      rdaddress_q <= '0;
      remaining_q <= '0;
      data_byte_q <= '0;
      sum_q       <= '0;
      lat_q       <= '0;
      send_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdaddress_q <= rdaddress_d;
      remaining_q <= remaining_d;
      data_byte_q <= data_byte_d;
      sum_q       <= sum_d;
      lat_q       <= lat_d;
      send_en_q   <= send_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus.rdaddress    = rdaddress_q;
  assign bus.Data_byte    = data_byte_q;
  assign bus.Uart_send_en = send_en_q;
  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign bus.Aborted      = aborted_q;
endmodule

// File: tb/tb_dpram_uart_reader.sv
// Directed bench: RAM model with read latency, transmitter responder, and a
// scoreboard of expected transmitted bytes/addresses.
module tb_dpram_uart_reader;
  localparam int RD_LAT = 2;
  localparam int TX_DLY = 3;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  dpram_uart_reader_if #(.ADDR_W(8), .LEN_W(9)) bus ();

  dpram_uart_reader #(.ADDR_W(8), .LEN_W(9), .RD_LAT(RD_LAT), .APPEND_SUM(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus)
  );

  typedef struct { logic [7:0] d; logic [7:0] a; bit ca; } exp_t;
  exp_t sb[$];

  logic [7:0] mem [256];
  logic [7:0] rp  [RD_LAT];
  int tests = 0, fails = 0;
  int cyc = 0, send_cnt = 0, done_cnt = 0, start_cyc = 0;
  logic done_ab;
  int send_cyc_q[$];

  always @(posedge Clk) begin
    rp[0] <= mem[bus.rdaddress];
    for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
    cyc <= cyc + 1;
  end
  assign bus.q = rp[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: counts pulses and checks every transmitted byte against the scoreboard.
  initial begin
    forever begin
      @(negedge Clk);
      if (bus.Done === 1'b1) begin done_cnt++; done_ab = bus.Aborted; end
      if (bus.Uart_send_en === 1'b1) begin
        send_cnt++;
        send_cyc_q.push_back(cyc);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("data_byte", 32'(bus.Data_byte), 32'(e.d));
          if (e.ca) chk("rdaddress", 32'(bus.rdaddress), 32'(e.a));
        end
      end
    end
  end

  // Transmitter model: acknowledges each byte TX_DLY cycles after its send pulse.
  initial begin
    bus.Uart_tx_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (bus.Uart_send_en === 1'b1) begin
        repeat (TX_DLY) @(negedge Clk);
        bus.Uart_tx_done = 1'b1;
        @(negedge Clk);
        bus.Uart_tx_done = 1'b0;
      end
    end
  end

  task automatic push_burst(input logic [7:0] a, input int n, input bit with_sum);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.a = a + 8'(i); e.d = mem[e.a]; e.ca = 1'b1;
      s = s + e.d;
      sb.push_back(e);
    end
    if (with_sum) begin
      exp_t e;
      e.a = 8'h00; e.d = s; e.ca = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic start_burst(input logic [7:0] a, input logic [8:0] len);
    @(negedge Clk);
    bus.Start_addr = a; bus.Length = len; bus.Start = 1'b1;
    start_cyc = cyc;
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 6000) begin @(negedge Clk); n++; end
    chk(tag, 32'(done_cnt != d0), 1);
  endtask

  task automatic wait_sends(input int target);
    int n;
    n = 0;
    while (send_cnt < target && n < 200) begin @(negedge Clk); n++; end
    chk("send_wait", 32'(send_cnt >= target), 1);
  endtask

  initial begin
    int sb0, db0, n;
    Rst_n = 1'b0;
    bus.Start = 1'b0; bus.Start_addr = '0; bus.Length = '0; bus.Abort = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33;

    #3;
    chk("rst_rdaddress", 32'(bus.rdaddress), 0);
    chk("rst_data_byte", 32'(bus.Data_byte), 0);
    chk("rst_send_en", 32'(bus.Uart_send_en), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_aborted", 32'(bus.Aborted), 0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;

    // Basic burst with checksum 0x11+0x22+0x33 = 0x66.
    sb0 = send_cnt; db0 = done_cnt;
    push_burst(8'h10, 3, 1'b1);
    chk("t1_sum_model", 32'(sb[3].d), 32'h66);
    start_burst(8'h10, 9'd3);
    wait_done("t1_done");
    chk("t1_sends", 32'(send_cnt - sb0), 4);
    chk("t1_latency", 32'(send_cyc_q[sb0] - start_cyc), 32'(RD_LAT + 2));
    chk("t1_aborted", 32'(done_ab), 0);
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // Address wrap 0xFE -> 0x01.
    sb0 = send_cnt;
    push_burst(8'hFE, 4, 1'b1);
    start_burst(8'hFE, 9'd4);
    wait_done("t2_done");
    chk("t2_sends", 32'(send_cnt - sb0), 5);
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // Zero length: no bytes, Busy for two cycles, single Done.
    sb0 = send_cnt; db0 = done_cnt;
    start_burst(8'h33, 9'd0);
    n = 0;
    while (bus.Busy === 1'b1 && n < 20) begin n++; @(negedge Clk); end
    chk("t3_busy_cycles", 32'(n), 2);
    repeat (5) @(negedge Clk);
    chk("t3_sends", 32'(send_cnt - sb0), 0);
    chk("t3_dones", 32'(done_cnt - db0), 1);

    // Second Start while a byte is in flight is ignored.
    sb0 = send_cnt; db0 = done_cnt;
    push_burst(8'h40, 3, 1'b1);
    start_burst(8'h40, 9'd3);
    wait_sends(sb0 + 1);
    start_burst(8'h00, 9'd7);
    wait_done("t4_done");
    repeat (20) @(negedge Clk);
    chk("t4_sends", 32'(send_cnt - sb0), 4);
    chk("t4_dones", 32'(done_cnt - db0), 1);
    chk("t4_sb_empty", 32'(sb.size()), 0);

    // Abort while byte 2 of 5 is in flight.
    sb0 = send_cnt;
    push_burst(8'h80, 2, 1'b0);
    start_burst(8'h80, 9'd5);
    wait_sends(sb0 + 2);
    bus.Abort = 1'b1;
    wait_done("t5_done");
    bus.Abort = 1'b0;
    repeat (10) @(negedge Clk);
    chk("t5_sends", 32'(send_cnt - sb0), 2);
    chk("t5_aborted", 32'(done_ab), 1);
    chk("t5_aborted_held", 32'(bus.Aborted), 1);
    chk("t5_sb_empty", 32'(sb.size()), 0);

    // Asynchronous reset during the RD_WAIT of byte 3.
    sb0 = send_cnt;
    push_burst(8'hA0, 5, 1'b1);
    start_burst(8'hA0, 9'd5);
    wait_sends(sb0 + 2);
    n = 0;
    do begin @(posedge Clk); n++; end while (bus.Uart_tx_done !== 1'b1 && n < 50);
    #2 Rst_n = 1'b0;
    #1;
    chk("ar_rdaddress", 32'(bus.rdaddress), 0);
    chk("ar_data_byte", 32'(bus.Data_byte), 0);
    chk("ar_busy", 32'(bus.Busy), 0);
    chk("ar_aborted", 32'(bus.Aborted), 0);
    chk("ar_send_en", 32'(bus.Uart_send_en), 0);
    sb.delete();
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (15) @(negedge Clk);
    chk("ar_no_sends", 32'(send_cnt - sb0), 2);
    chk("ar_idle_busy", 32'(bus.Busy), 0);

    // Full burst of 2^ADDR_W bytes with one wrap.
    sb0 = send_cnt;
    push_burst(8'h05, 256, 1'b1);
    start_burst(8'h05, 9'd256);
    wait_done("t7_done");
    chk("t7_sends", 32'(send_cnt - sb0), 257);
    chk("t7_aborted", 32'(done_ab), 0);
    chk("t7_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dpram_uart_reader.md
Name: dpram_uart_reader

Overview:
- Read-side sequencer for the UART/dual-port RAM loopback path.
- The RX path writes bytes into RAM. This block reads a contiguous burst back out of the RAM read port and hands each byte to the UART byte transmitter.
- It handles RAM read latency, the one-byte-at-a-time handshake with the transmitter, and address wrap-around. It can optionally append an 8-bit additive checksum byte.
- It sits between the key/command logic (Start) and the RAM read port plus the UART byte transmitter.

Parameters:
- ADDR_W, 8, RAM address width; the address wraps modulo 2^ADDR_W.
- LEN_W, 9, width of Length; must hold the value 2^ADDR_W.
- RD_LAT, 2, clocks from a rdaddress update until q is valid; legal range 1..3.
- APPEND_SUM, 1, when 1, send the checksum byte after the data bytes.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Start_addr  in  ADDR_W  first RAM address; captured on an accepted Start.
- Length  in  LEN_W  number of data bytes; captured on an accepted Start.
- Abort  in  1  level request to stop after the byte currently in flight.
- rdaddress  out  ADDR_W  RAM read address, registered.
- q  in  8  RAM read data.
- Uart_send_en  out  1  one-cycle start pulse to the byte transmitter.
- Data_byte  out  8  byte to transmit; registered, held stable until the next Uart_send_en.
- Uart_tx_done  in  1  one-cycle pulse from the transmitter when the byte has been sent.
- Busy  out  1  high from Start acceptance until Done.
- Done  out  1  one-cycle pulse at the end of a burst.
- Aborted  out  1  valid with Done; 1 means the burst was cut short.

Behaviour:
- Reset values: rdaddress=0, Data_byte=0, Uart_send_en=0, Busy=0, Done=0, Aborted=0. Internal state: IDLE, byte counter=0, sum=0, latency counter=0.
- Reset mid-burst returns to IDLE immediately; no further Uart_send_en is issued.
- States: IDLE, RD_WAIT, SEND, WAIT_DONE, SUM_SEND, SUM_WAIT, FINISH.
- IDLE:
  - On Start=1: capture Start_addr into rdaddress, load the remaining count from Length, clear sum, set Busy=1.
  - If Length=0, go to FINISH. Otherwise go to RD_WAIT with the latency counter loaded to RD_LAT.
  - Start is ignored in every state except IDLE.
- RD_WAIT: decrement the latency counter; when it expires, go to SEND.
- SEND (one cycle):
  - Data_byte<=q, Uart_send_en=1, sum<=sum+q (mod 256), remaining<=remaining-1.
  - Next state: WAIT_DONE.
- WAIT_DONE: hold until Uart_tx_done=1, then choose:
  - Abort=1: Aborted<=1, go to FINISH (no checksum).
  - Else if remaining>0: rdaddress<=rdaddress+1 (wraps all-ones to 0), go to RD_WAIT.
  - Else if APPEND_SUM=1: go to SUM_SEND.
  - Else: go to FINISH.
- SUM_SEND (one cycle): Data_byte<=sum, Uart_send_en=1, go to SUM_WAIT.
- SUM_WAIT: on Uart_tx_done, go to FINISH. Abort is ignored once the checksum is in flight.
- FINISH (one cycle): Done=1, Busy=0 on the next clock, return to IDLE.
  - Aborted holds its value until the next accepted Start clears it.
- Latency: Start accepted at edge N gives Uart_send_en at edge N+RD_LAT+1. Each later byte's Uart_send_en comes RD_LAT+1 clocks after its Uart_tx_done.
- Uart_tx_done received outside WAIT_DONE/SUM_WAIT is ignored.
- Uart_tx_done arriving in the same cycle as Abort is honoured: the current byte is counted as sent, then the burst stops.
- A full burst is Length=2^ADDR_W: every address is sent exactly once, with one wrap.
- Length greater than 2^ADDR_W is outside the contract.

Test Plan:
- RAM[0x10..0x12]=0x11,0x22,0x33; Start_addr=0x10, Length=3, APPEND_SUM=1 -> transmitted bytes 0x11,0x22,0x33,0x66; exactly 4 Uart_send_en pulses; Done pulse with Aborted=0.
- Start_addr=0xFE, Length=4 -> rdaddress sequence 0xFE,0xFF,0x00,0x01; checksum equals the low 8 bits of the byte sum.
- Length=0 -> no Uart_send_en; Busy high for 2 cycles; Done pulses once.
- Second Start pulsed during WAIT_DONE -> ignored; byte count unchanged; only one Done.
- Abort raised while byte 2 of 5 is in flight -> 2 bytes sent, no checksum, Done with Aborted=1.
- Rst_n dropped during RD_WAIT of byte 3 -> all outputs go to reset values asynchronously; no Uart_send_en until a new Start.
